// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared funct3 codes, LSU state encoding and lane helpers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Pick the addressed byte/half out of a word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  funct3);
        logic [31:0] sh;
        logic [15:0] half;
        sh   = word >> {off, 3'b000};
        half = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    lane_extract = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   lane_extract = {24'h0, sh[7:0]};
            F3_H:    lane_extract = {{16{half[15]}}, half};
            F3_HU:   lane_extract = {16'h0, half};
            F3_W:    lane_extract = word;
            default: lane_extract = 32'h0;
        endcase
    endfunction

    // Replace the addressed byte/half of a word with the low store bytes.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  funct3);
        logic [31:0] res;
        res = word;
        case (funct3)
            F3_B: res[{off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (off[1]) res[31:16] = wdata[15:0];
                else        res[15:0]  = wdata[15:0];
            end
            F3_W:    res = wdata;
            default: res = word;
        endcase
        lane_merge = res;
    endfunction

    // Size/alignment legality only; the address range check lives in the LSU.
    function automatic logic access_err(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
        case (funct3)
            F3_B:          access_err = 1'b0;
            F3_H:          access_err = off[0];
            F3_W:          access_err = (off != 2'b00);
            F3_BU, F3_HU:  access_err = write;
            default:       access_err = 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_unit.sv
// ============================================================================
//  Module   : dmem_lane_unit
//  Purpose  : Combinational load-lane extraction and store-lane merge.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] extracted,
    output logic [31:0] merged
);

    assign extracted = lane_extract(word, off, funct3);
    assign merged    = lane_merge(word, wdata, off, funct3);

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
// ============================================================================
//  Module   : dmem_lsu
//  Purpose  : Single-outstanding load/store unit with sub-word RMW stores.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_data_i
);

    state_t      state, state_n;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_err;
    logic [31:0] extracted;
    logic [31:0] merged;

    assign req_err = access_err(req_write_i, req_funct3_i, req_addr_i[1:0]) ||
                     (req_addr_i >= 32'(MEM_BYTES));

    dmem_lane_unit u_lane (
        .word      (mem_data_i),
        .wdata     (wdata_q),
        .off       (addr_q[1:0]),
        .funct3    (f3_q),
        .extracted (extracted),
        .merged    (merged)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // wdata_q is reused as the write buffer: the merged word replaces it in RMW_RD.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        f3_q    <= req_funct3_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        rdata_q <= 32'h0;
                        err_q   <= req_err;
                    end
                end
                ST_RD:     rdata_q <= extracted;
                ST_RMW_RD: wdata_q <= merged;
                default:   ;
            endcase
        end
    end

    always_comb begin
        state_n      = state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = 32'h0;
        resp_err_o   = 1'b0;
        busy_o       = 1'b1;
        mem_addr_o   = 32'h0;
        mem_data_o   = 32'h0;
        mem_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_o      = 1'b0;
                req_ready_o = rst_i;
                if (req_valid_i) begin
                    if (req_err)            state_n = ST_RESP;
                    else if (!req_write_i)  state_n = ST_RD;
                    else if (req_funct3_i == F3_W) state_n = ST_WR;
                    else                    state_n = ST_RMW_RD;
                end
            end
            ST_RD: begin
                mem_read_o = 1'b1;
                mem_addr_o = {addr_q[31:2], 2'b00};
                state_n    = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_read_o = 1'b1;
                mem_addr_o = {addr_q[31:2], 2'b00};
                state_n    = ST_WR;
            end
            ST_WR: begin
                mem_write_o = 1'b1;
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_data_o  = wdata_q;
                state_n     = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = rdata_q;
                resp_err_o   = err_q;
                if (resp_ready_i) state_n = ST_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
